// File: rtl/mem_pipe_pkg.sv
// Shared types and helpers for the pipelined single-port memory.
package mem_pipe_pkg;

  typedef enum logic {INIT, READY} state_t;

  localparam int unsigned MAX_RD_LAT = 4;
  localparam int unsigned MAX_DW     = 256;
  localparam int unsigned MAX_BE     = MAX_DW / 8;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_w,
                                                 input logic [MAX_DW-1:0] new_w,
                                                 input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MAX_BE); i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_pipe_if.sv
// Request/response bundle between a memory client and mem_pipe.
interface mem_pipe_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) ();
  logic          clr;
  logic          req_valid;
  logic          req_ready;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] be;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          busy;

  modport master (
    output clr, req_valid, wr_en, addr, wdata, be,
    input  req_ready, rd_valid, rd_data, rd_err, busy
  );

  modport slave (
    input  clr, req_valid, wr_en, addr, wdata, be,
    output req_ready, rd_valid, rd_data, rd_err, busy
  );
endinterface

// File: rtl/mem_rd_pipe.sv
// Read-return delay line; data and err only advance with a valid beat so the
// output holds its last returned value between pulses.
module mem_rd_pipe
  import mem_pipe_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic          in_err_i,
  input  logic [DW-1:0] in_data_i,
  output logic          rd_valid_o,
  output logic          rd_err_o,
  output logic [DW-1:0] rd_data_o
);

  localparam int unsigned LAT = (RD_LAT < 1) ? 1 :
                                (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] err_q;
  logic [DW-1:0]  dat_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < int'(LAT); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      if (in_valid_i) begin
        err_q[0] <= in_err_i;
        dat_q[0] <= in_data_i;
      end
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          err_q[i] <= err_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign rd_valid_o = vld_q[LAT-1];
  assign rd_err_o   = err_q[LAT-1];
  assign rd_data_o  = dat_q[LAT-1];

endmodule

// File: rtl/mem_pipe.sv
// Single-port memory with byte enables, ready/valid requests, pipelined read
// return and an init sweep that fills every word with INIT_VAL.
module mem_pipe
  import mem_pipe_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  mem_pipe_if.slave bus
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          accept_c;
  logic          in_range_c;
  logic [CW-1:0] idx_c;
  logic [DW-1:0] rd_word_c;

  assign accept_c   = bus.req_valid && req_ready_q && !rst;
  assign in_range_c = 32'(bus.addr) < DEPTH;
  assign idx_c      = bus.addr[CW-1:0];
  assign rd_word_c  = in_range_c ? mem_q[idx_c] : '0;

  // Sweep/ready control; clr restarts the sweep from word 0 in either state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    busy_d      = 1'b1;
    unique case (state_q)
      INIT: begin
        if (bus.clr)            cnt_d   = '0;
        else if (cnt_q == LAST) state_d = READY;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      READY: begin
        if (bus.clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
    req_ready_d = (state_d == READY);
    busy_d      = (state_d == INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Storage: sweep writes own the port while INIT; out-of-range writes drop.
  always_ff @(posedge clk) begin
    if (!rst && state_q == INIT) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (accept_c && bus.wr_en && in_range_c) begin
      mem_q[idx_c] <= DW'(be_merge(MAX_DW'(mem_q[idx_c]), MAX_DW'(bus.wdata),
                                   MAX_BE'(bus.be)));
    end
  end

  mem_rd_pipe #(
    .DW    (DW),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid_i(accept_c && !bus.wr_en),
    .in_err_i  (!in_range_c),
    .in_data_i (rd_word_c),
    .rd_valid_o(bus.rd_valid),
    .rd_err_o  (bus.rd_err),
    .rd_data_o (bus.rd_data)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;

endmodule
